// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative multiplier: default widths and FSM state encodings.
package mult_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 6;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_t;

endpackage

// File: rtl/mult_unit_datapath.sv
// Radix-2 shift-add datapath: operand magnitudes, partial-product accumulator, final sign fix-up.
module mult_unit_datapath
    import mult_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  sign,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product
);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;
    logic                neg;
    logic [DATA_W-1:0]   addend;
    logic [DATA_W:0]     sum;

    // The most negative value keeps its bit pattern, which is its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              signed_op);
        return (signed_op && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] fix_sign(input logic [2*DATA_W-1:0] v,
                                                     input logic                negate);
        return negate ? (~v + (2*DATA_W)'(1)) : v;
    endfunction

    always_comb begin
        addend = acc[0] ? mcand : '0;
        sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, addend};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            mcand <= magnitude(a, sign);
            acc   <= {{DATA_W{1'b0}}, magnitude(b, sign)};
            neg   <= sign & (a[DATA_W-1] ^ b[DATA_W-1]);
        end else if (step) begin
            acc   <= {sum, acc[DATA_W-1:1]};
        end
    end

    assign product = fix_sign(acc, neg);

endmodule

// File: rtl/mult_unit.sv
// Shared iterative multiplier for both issue lanes: lane arbitration, control FSM and HI/LO registers.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              startmult_e_0,
    input  logic              multsign_e_0,
    input  logic [DATA_W-1:0] srca_e_0,
    input  logic [DATA_W-1:0] writedata_e_0,
    input  logic              startmult_e_1,
    input  logic              multsign_e_1,
    input  logic [DATA_W-1:0] srca_e_1,
    input  logic [DATA_W-1:0] writedata_e_1,
    output logic              mult_busy,
    output logic              mult_done,
    output logic              mult_conflict,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    mult_state_t          state;
    mult_state_t          state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 step;
    logic                 last_step;
    logic                 sel_sign;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [2*DATA_W-1:0]  product;

    assign accept    = (state == MULT_IDLE) & ~stall_e & (startmult_e_0 | startmult_e_1);
    assign step      = (state == MULT_RUN);
    assign last_step = step && (cnt == CNT_W'(DATA_W - 1));

    // Lane 0 has priority when both lanes issue a multiply together.
    always_comb begin
        sel_sign = multsign_e_1;
        sel_a    = srca_e_1;
        sel_b    = writedata_e_1;
        if (startmult_e_0) begin
            sel_sign = multsign_e_0;
            sel_a    = srca_e_0;
            sel_b    = writedata_e_0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MULT_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MULT_IDLE: if (accept) state_next = MULT_RUN;
            MULT_RUN:  if (last_step) state_next = MULT_DONE;
            MULT_DONE: state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    always_comb begin
        mult_busy     = (state != MULT_IDLE);
        mult_done     = (state == MULT_DONE);
        mult_conflict = accept & startmult_e_0 & startmult_e_1;
    end

    always_ff @(posedge clk) begin
        if (reset)       cnt <= '0;
        else if (accept) cnt <= '0;
        else if (step)   cnt <= cnt + CNT_W'(1);
    end

    // HI/LO only change on the edge leaving DONE, so readers see the old product until then.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (state == MULT_DONE) begin
            hi_out <= product[2*DATA_W-1:DATA_W];
            lo_out <= product[DATA_W-1:0];
        end
    end

    mult_unit_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .step    (step),
        .sign    (sel_sign),
        .a       (sel_a),
        .b       (sel_b),
        .product (product)
    );

endmodule
